// File: rtl/skylark_dbus_if.sv
`default_nettype none
// ============================================================================
//  Module      : skylark_dbus_if
//  Description : Core-to-data-bus signal bundle (store strobe, address,
//                store data, load data) with core and bus-side views.
//  Revision    : 1.0  initial release
// ============================================================================
interface skylark_dbus_if;
  logic        MemWriteW;
  logic [31:0] ALUResultW;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWriteW, output ALUResultW, output WriteData, input ReadData);
  modport slave  (input MemWriteW, input ALUResultW, input WriteData, output ReadData);
endinterface
`default_nettype wire

// File: rtl/skylark_dbus.sv
`default_nettype none
// ============================================================================
//  Module      : skylark_dbus
//  Description : Data-side bus for the skylark core. Decodes word accesses
//                into a data RAM, a UART transmitter with TX FIFO and a
//                free-running cycle counter.
//  Revision    : 1.0  initial release
// ============================================================================
module skylark_dbus #(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic      clk,
  input  wire logic      reset,
  skylark_dbus_if.slave  bus,
  output logic           uart_tx
);

  localparam int          c_ramAw     = $clog2(RAM_WORDS);
  localparam int          c_ptrW      = $clog2(FIFO_DEPTH);
  localparam int          c_cntW      = c_ptrW + 1;
  localparam int          c_tmrW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [29:0] c_uartDataWa = 30'h2000_0000;
  localparam logic [29:0] c_uartStatWa = 30'h2000_0001;
  localparam logic [29:0] c_cyclesWa   = 30'h2000_0002;
  localparam logic [c_cntW-1:0] c_fifoDepth = c_cntW'(FIFO_DEPTH);
  localparam logic [c_tmrW-1:0] c_bitLast   = c_tmrW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } txState_t;

  // ---------------------------------------------------------------- decode
  logic [29:0]        w_wordAddr;
  logic               w_ramSel;
  logic [c_ramAw-1:0] w_ramIdx;
  logic               w_isUartData;
  logic               w_isUartStat;
  logic               w_isCycles;
  logic               w_unusedAddrBits;

  assign w_wordAddr   = bus.ALUResultW[31:2];
  // RAM occupies the bottom of the low half; anything above its depth is unmapped
  assign w_ramSel     = ~bus.ALUResultW[31] && (bus.ALUResultW[30:2+c_ramAw] == '0);
  assign w_ramIdx     = bus.ALUResultW[2+c_ramAw-1:2];
  assign w_isUartData = (w_wordAddr == c_uartDataWa);
  assign w_isUartStat = (w_wordAddr == c_uartStatWa);
  assign w_isCycles   = (w_wordAddr == c_cyclesWa);
  assign w_unusedAddrBits = ^bus.ALUResultW[1:0];

  // ---------------------------------------------------------------- state
  logic [31:0]       r_mem [RAM_WORDS];
  logic [31:0]       r_cycles;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_ptrW-1:0] r_rdPtr;
  logic [c_cntW-1:0] r_count;
  logic              r_overflow;
  txState_t          r_state;
  logic [c_tmrW-1:0] r_timer;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;
  logic              r_tx;

  txState_t          w_stateNext;
  logic [c_tmrW-1:0] w_timerNext;
  logic [2:0]        w_bitNext;
  logic [7:0]        w_shiftNext;
  logic              w_txNext;
  logic              w_pop;
  logic              w_pushReq;
  logic              w_pushOk;
  logic              w_fifoEmpty;
  logic              w_fifoFull;
  logic              w_bitEnd;

  assign w_fifoEmpty = (r_count == '0);
  assign w_fifoFull  = (r_count == c_fifoDepth);
  assign w_pushReq   = bus.MemWriteW && w_isUartData;
  // A full FIFO still accepts when the head is leaving in the same cycle
  assign w_pushOk    = w_pushReq && (!w_fifoFull || w_pop);
  assign w_bitEnd    = (r_timer == c_bitLast);
  assign uart_tx     = r_tx;

  // RAM write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (bus.MemWriteW && w_ramSel) r_mem[w_ramIdx] <= bus.WriteData;
  end

  // Free-running cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycles <= '0;
    else       r_cycles <= r_cycles + 32'd1;
  end

  // FIFO storage; only the pointers/count need clearing on reset
  always_ff @(posedge clk) begin
    if (w_pushOk) r_fifo[r_wrPtr] <= bus.WriteData[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)    r_rdPtr <= r_rdPtr + 1'b1;
      if (w_pushOk && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_pushOk && w_pop) r_count <= r_count - 1'b1;
      if (bus.MemWriteW && w_isUartStat)  r_overflow <= 1'b0;
      else if (w_pushReq && !w_pushOk)    r_overflow <= 1'b1;
    end
  end

  // TX state register; the line output is registered from the next-state logic
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_timer  <= w_timerNext;
      r_bitIdx <= w_bitNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
    end
  end

  // TX next-state: the line value for each new bit is decided as it begins
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer + 1'b1;
    w_bitNext   = r_bitIdx;
    w_shiftNext = r_shift;
    w_txNext    = r_tx;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timerNext = '0;
        w_txNext    = 1'b1;
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_shiftNext = r_fifo[r_rdPtr];
          w_stateNext = S_START;
          w_txNext    = 1'b0;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_timerNext = '0;
          w_bitNext   = '0;
          w_stateNext = S_DATA;
          w_txNext    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          w_timerNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = S_STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitNext   = r_bitIdx + 3'd1;
            w_shiftNext = {1'b0, r_shift[7:1]};
            w_txNext    = r_shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          w_timerNext = '0;
          if (!w_fifoEmpty) begin
            w_pop       = 1'b1;
            w_shiftNext = r_fifo[r_rdPtr];
            w_stateNext = S_START;
            w_txNext    = 1'b0;
          end else begin
            w_stateNext = S_IDLE;
            w_txNext    = 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = S_IDLE;
        w_timerNext = '0;
        w_txNext    = 1'b1;
      end
    endcase
  end

  // Load data mux; unmapped addresses and UART_DATA read as zero
  always_comb begin
    bus.ReadData = 32'd0;
    if (w_ramSel) begin
      bus.ReadData = r_mem[w_ramIdx];
    end else if (w_isUartStat) begin
      bus.ReadData = {16'd0, 8'(r_count), 4'd0, r_overflow, w_fifoEmpty,
                      w_fifoFull, (r_state != S_IDLE)};
    end else if (w_isCycles) begin
      bus.ReadData = r_cycles;
    end
  end

endmodule
`default_nettype wire
